// File: rtl/pixel_median_sched.sv
// rtl/pixel_median_sched.sv - per-channel N-pixel window median via one time-multiplexed compare-exchange unit
// Optional out_min/out_max ports: define PIXEL_MEDIAN_MINMAX_EN.
package pixel_pkg;
    typedef struct packed {
        logic [7:0] red;
        logic [7:0] grn;
        logic [7:0] blu;
    } pixel_t;
endpackage

module pixel_sort
    import pixel_pkg::*;
(
    input  pixel_t pix_a,
    input  pixel_t pix_b,
    output pixel_t pix_l,
    output pixel_t pix_h
);
    // Each channel is exchanged on its own, so a sorted buffer holds ascending columns.
    always_comb begin
        pix_l.red = (pix_a.red <= pix_b.red) ? pix_a.red : pix_b.red;
        pix_h.red = (pix_a.red <= pix_b.red) ? pix_b.red : pix_a.red;
        pix_l.grn = (pix_a.grn <= pix_b.grn) ? pix_a.grn : pix_b.grn;
        pix_h.grn = (pix_a.grn <= pix_b.grn) ? pix_b.grn : pix_a.grn;
        pix_l.blu = (pix_a.blu <= pix_b.blu) ? pix_a.blu : pix_b.blu;
        pix_h.blu = (pix_a.blu <= pix_b.blu) ? pix_b.blu : pix_a.blu;
    end
endmodule

module pixel_median_sched
    import pixel_pkg::*;
#(
    parameter int N = 9
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  pixel_t in_pix,
    output logic   out_valid,
    input  logic   out_ready,
    output pixel_t out_pix,
`ifdef PIXEL_MEDIAN_MINMAX_EN
    output pixel_t out_min,
    output pixel_t out_max,
`endif
    output logic   busy
);
    localparam int CW      = $clog2(N);
    localparam int MID     = (N - 1) / 2;
    localparam int PR_LAST = (N - 3) / 2;

    typedef enum logic [1:0] {LOAD, SORT, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]   ph_q, ph_d;
    logic [CW-1:0]   pr_q, pr_d;
    pixel_t          buf_q [N];
    pixel_t          buf_d [N];

    logic [CW-1:0]   sidx;
    logic [CW-1:0]   sidx_p1;
    pixel_t          s_l, s_h;

    // Even phases start at pair (0,1), odd phases at (1,2).
    assign sidx    = CW'(2 * pr_q) + CW'(ph_q[0]);
    assign sidx_p1 = sidx + CW'(1);

    pixel_sort u_sort (
        .pix_a (buf_q[sidx]),
        .pix_b (buf_q[sidx_p1]),
        .pix_l (s_l),
        .pix_h (s_h)
    );

    assign in_ready  = (state_q == LOAD) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != LOAD);
    assign out_pix   = buf_q[MID];
`ifdef PIXEL_MEDIAN_MINMAX_EN
    assign out_min   = buf_q[0];
    assign out_max   = buf_q[N-1];
`endif

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        ph_d     = ph_q;
        pr_d     = pr_q;
        buf_d    = buf_q;
        case (state_q)
            LOAD: begin
                if (in_valid && in_ready) begin
                    buf_d[ld_cnt_q] = in_pix;
                    if (ld_cnt_q == CW'(N - 1)) begin
                        ld_cnt_d = '0;
                        ph_d     = '0;
                        pr_d     = '0;
                        state_d  = SORT;
                    end else begin
                        ld_cnt_d = ld_cnt_q + CW'(1);
                    end
                end
            end
            SORT: begin
                buf_d[sidx]    = s_l;
                buf_d[sidx_p1] = s_h;
                if (pr_q == CW'(PR_LAST)) begin
                    pr_d = '0;
                    if (ph_q == CW'(N - 1)) begin
                        state_d = DONE;
                    end else begin
                        ph_d = ph_q + CW'(1);
                    end
                end else begin
                    pr_d = pr_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD;
            ld_cnt_q <= '0;
            ph_q     <= '0;
            pr_q     <= '0;
            for (int k = 0; k < N; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            ph_q     <= ph_d;
            pr_q     <= pr_d;
            buf_q    <= buf_d;
        end
    end
endmodule

// File: tb/tb_pixel_median_sched.sv
// tb/tb_pixel_median_sched.sv - randomized bench for pixel_median_sched against a sort-based median model
module tb_pixel_median_sched;
    import pixel_pkg::*;

    localparam int N = 9;
    localparam int SORT_CYC = N * (N - 1) / 2;
    localparam int PERIOD = N + SORT_CYC + 1;

    logic   clk = 1'b0;
    logic   rst;
    logic   in_valid;
    logic   in_ready;
    pixel_t in_pix;
    logic   out_valid;
    logic   out_ready;
    pixel_t out_pix;
    logic   busy;
`ifdef PIXEL_MEDIAN_MINMAX_EN
    pixel_t out_min;
    pixel_t out_max;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    pixel_t last_med;
    pixel_t win [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pixel_median_sched #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
`ifdef PIXEL_MEDIAN_MINMAX_EN
        .out_min   (out_min),
        .out_max   (out_max),
`endif
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // k-th smallest value of each channel, taken independently.
    function automatic pixel_t ref_rank(input pixel_t w [N], input int rank);
        int r[$];
        int g[$];
        int b[$];
        pixel_t p;
        for (int k = 0; k < N; k++) begin
            r.push_back(int'(w[k].red));
            g.push_back(int'(w[k].grn));
            b.push_back(int'(w[k].blu));
        end
        r.sort();
        g.sort();
        b.sort();
        p.red = 8'(r[rank]);
        p.grn = 8'(g[rank]);
        p.blu = 8'(b[rank]);
        return p;
    endfunction

    function automatic pixel_t rand_pix();
        return pixel_t'(24'($urandom));
    endfunction

    // Loads win[] with gap idle cycles before each pixel (gap<0: random),
    // checks latency and result, holds out_ready low for hold cycles, then handshakes.
    task automatic run_window(input int gap, input int hold, input bit junk);
        pixel_t exp_med;
        int lat;
        exp_med = ref_rank(win, (N - 1) / 2);
        for (int k = 0; k < N; k++) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            repeat (g) begin
                in_valid = 1'b0;
                in_pix = rand_pix();
                @(posedge clk);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_pix = win[k];
            check_eq("load_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = junk;
        in_pix = rand_pix();
        check_eq("sort_busy", 32'(busy), 32'd1);
        check_eq("sort_in_ready", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (junk) out_ready = 1'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_pix = rand_pix();
        end
        out_ready = 1'b0;
        check_eq("latency", 32'(lat), 32'(SORT_CYC));
        check_eq("median", 32'(out_pix), 32'(exp_med));
        last_med = out_pix;
`ifdef PIXEL_MEDIAN_MINMAX_EN
        check_eq("min", 32'(out_min), 32'(ref_rank(win, 0)));
        check_eq("max", 32'(out_max), 32'(ref_rank(win, N - 1)));
`endif
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            in_pix = rand_pix();
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_pix", 32'(out_pix), 32'(exp_med));
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check_eq("post_valid", 32'(out_valid), 32'd0);
        check_eq("post_busy", 32'(busy), 32'd0);
        check_eq("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int t_out [2];
        int outs;
        int guard;
        int wi;
        int ki;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_pix = '0;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_pix", 32'(out_pix), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rel_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        for (int k = 0; k < N; k++) win[k] = '{red: 8'(9 - k), grn: 8'h10, blu: 8'h10};
        run_window(0, 0, 1'b0);
        check_eq("t1_const", 32'(last_med), 32'h051010);

        for (int k = 0; k < N; k++)
            win[k] = '{red: 8'(k), grn: 8'(8 - k), blu: (k == 0) ? 8'd200 : (k == N - 1) ? 8'd255 : 8'd3};
        run_window(0, 0, 1'b0);
        check_eq("t2_const", 32'(last_med), 32'h040403);

        for (int k = 0; k < N; k++) win[k] = rand_pix();
        run_window(0, 20, 1'b0);

        for (int k = 0; k < N; k++) win[k] = rand_pix();
        run_window(1, 2, 1'b1);

        for (int w = 0; w < 6; w++) begin
            for (int k = 0; k < N; k++) win[k] = rand_pix();
            run_window(-1, int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Reset in the middle of sorting.
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_pix = rand_pix();
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd0);
        check_eq("abort_out_pix", 32'(out_pix), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) win[k] = 24'hFFFFFF;
        run_window(0, 0, 1'b0);
        check_eq("ff_const", 32'(last_med), 32'hFFFFFF);

        // Back-to-back extremes with continuous valid/ready.
        out_ready = 1'b1;
        outs = 0;
        guard = 0;
        wi = 0;
        ki = 0;
        while (outs < 2 && guard < 300) begin
            if (out_valid) begin
                t_out[outs] = cyc;
                check_eq("stream_pix", 32'(out_pix), (outs == 0) ? 32'h000000 : 32'hFFFFFF);
                outs++;
            end
            in_valid = (wi < 2);
            in_pix = (wi == 0) ? 24'h000000 : 24'hFFFFFF;
            if (in_valid && in_ready) begin
                ki++;
                if (ki == N) begin
                    ki = 0;
                    wi++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_eq("stream_outs", 32'(outs), 32'd2);
        if (outs == 2) check_eq("stream_spacing", 32'(t_out[1] - t_out[0]), 32'(PERIOD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
